fill_unit: RTL and testbench
============================

// Module: fill_unit
// PURPOSE
//  Parametrised successor to the single-pixel rectangle clear engine: walks an inclusive rectangle in raster order.
//  Each beat carries LANES horizontally adjacent pixels with a lane mask, under a valid/ready stream.
//  Supports abort and flags degenerate rectangles. Sits between the command/register front end and the framebuffer writer.
// PARAMETERS
//  COORD_W  16  width of every coordinate port and internal counter (unsigned)
//  COLOR_W  32  pixel colour width
//  LANES    4   pixels per output beat (>=1, power of two not required)
// PORTS
//  clk            in   1         single clock, rising edge
//  rst            in   1         synchronous, active-high reset
//  start          in   1         one-cycle request; sampled only in IDLE
//  abort          in   1         terminate an active walk
//  busy           out  1         high from accepted start until done
//  done           out  1         one-cycle completion pulse (normal, empty or aborted)
//  err_bad_rect   out  1         pulses with done when xmin>xmax or ymin>ymax
//  color          in   COLOR_W   fill colour, latched on start
//  xmin,ymin      in   COORD_W   inclusive top-left, latched on start
//  xmax,ymax      in   COORD_W   inclusive bottom-right, latched on start
//  pix_valid      out  1         beat available
//  pix_ready      in   1         downstream accepts beat (handshake = valid&&ready)
//  pix_x,pix_y    out  COORD_W   coordinate of lane 0
//  pix_mask       out  LANES     lane i valid when pix_x+i<=xmax
//  pix_color      out  COLOR_W   latched colour
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; latched config 0. Reset mid-walk drops pix_valid the next cycle, with no done pulse.
//  - States: IDLE -> RUN (start, rect valid) | DONE (start, rect empty); RUN -> DONE (last beat handshaken | abort); DONE -> IDLE after 1 cycle.
//  - start high in IDLE at edge N: config latched, busy=1 from N+1, first pix_valid at N+1 (pix_x=xmin, pix_y=ymin).
//  - start in RUN/DONE is ignored; config inputs may change freely after the accepting edge.
//  - Beat advance only on handshake: pix_x += LANES. If pix_x+LANES > xmax, the beat was the row tail: pix_x=xmin, pix_y+=1.
//  - The row tail with pix_y==ymax is the last beat: the handshake moves to DONE, and pix_valid is 0 the next cycle.
//  - While pix_valid && !pix_ready, pix_x/pix_y/pix_mask/pix_color are held stable; pix_valid is never withdrawn, except by abort or rst.
//  - pix_mask: bit i = (pix_x+i <= xmax). Always all ones except on the row tail; never zero while pix_valid.
//  - Arithmetic is done at COORD_W+1 bits, so xmax or ymax = 2^COORD_W-1 terminates without wrapping.
//  - Abort in RUN: a same-edge handshake still completes, counts as delivered, and is the final beat. Next cycle pix_valid=0, state DONE.
//  - Abort outside RUN has no effect.
//  - done=1 for exactly the DONE cycle; busy falls with it, same cycle. A new start is accepted from the following IDLE cycle.
//  - Empty rect: zero beats; done and err_bad_rect pulse at N+1, with busy=1 for that cycle only.
//  - Beats per row = ceil((xmax-xmin+1)/LANES). Total pix_valid-high cycles = beats when pix_ready is tied 1.
// STRUCTURE
//  - Shared package gfx_pkg holds: fill_state_t enum {IDLE,RUN,DONE}; rect_t struct {xmin,ymin,xmax,ymax}; coord_t typedef sized by COORD_W.
//  - One sub-module, fill_walker: the raster stepper (pix_x/pix_y counters, tail/last detection, mask generation).
//  - The fill_unit top keeps the FSM, the config latch and the handshake.
// TESTING
//  1. LANES=1, rect (0,0)-(3,2), ready=1: 12 beats, x 0..3 per y 0..2, mask=1, colour A5A5A5A5; done 1 cycle after last beat.
//  2. LANES=4, rect (1,0)-(6,1): per row, beats x=1 mask 1111 then x=5 mask 0011; 4 beats total.
//  3. Same as 2, with pix_ready random at 30% high: identical beat sequence; outputs stable while stalled; no lost or duplicated beat.
//  4. xmin=5, xmax=2: no pix_valid; done and err_bad_rect both pulse at N+1; busy high 1 cycle.
//  5. Abort on the 3rd beat of test 1, with ready=1 the same edge: exactly 3 beats delivered; done next cycle; restart then runs a full 12 beats.
//  6. COORD_W=8, rect (252,255)-(255,255), LANES=4: single beat x=252, mask 1111; terminates, no wrap to y=0. Also covers rst mid-walk and start-while-busy ignored.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared graphics types: FSM state encoding and rectangle bundle.
// Coordinate types here are the default-width view used on the command bus.
package gfx_pkg;

    localparam int GFX_COORD_W = 16;

    typedef logic [GFX_COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t xmin;
        coord_t ymin;
        coord_t xmax;
        coord_t ymax;
    } rect_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fill_state_t;

endpackage

// File: rtl/fill_walker.sv
// Raster stepper for fill_unit: lane-0 x/y counters, row-tail and last-beat
// detection, lane mask. Ports: load/load_x/load_y seed, step advances,
// xmin/xmax/ymax bound the walk, pix_x/pix_y/mask/last describe the beat.
module fill_walker #(
    parameter int COORD_W = 16,
    parameter int LANES   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [COORD_W-1:0] load_x,
    input  logic [COORD_W-1:0] load_y,
    input  logic               step,
    input  logic [COORD_W-1:0] xmin,
    input  logic [COORD_W-1:0] xmax,
    input  logic [COORD_W-1:0] ymax,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [LANES-1:0]   mask,
    output logic               last
);

    localparam int XW = COORD_W + 1;
    localparam logic [XW-1:0] LANES_X = XW'(LANES);

    logic [XW-1:0] x_ext;
    logic [XW-1:0] xmax_ext;
    logic          tail;

    // One extra bit so a row ending at the top of the coordinate range
    // is still detected as the tail instead of wrapping.
    assign x_ext    = {1'b0, pix_x};
    assign xmax_ext = {1'b0, xmax};
    assign tail     = (x_ext + LANES_X) > xmax_ext;
    assign last     = tail && (pix_y == ymax);

    always_comb begin
        mask = '0;
        for (int i = 0; i < LANES; i++) begin
            mask[i] = (x_ext + XW'(i)) <= xmax_ext;
        end
    end

    // The last beat never steps, so y cannot wrap past ymax.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_x <= '0;
            pix_y <= '0;
        end else if (load) begin
            pix_x <= load_x;
            pix_y <= load_y;
        end else if (step && !last) begin
            if (tail) begin
                pix_x <= xmin;
                pix_y <= pix_y + COORD_W'(1);
            end else begin
                pix_x <= pix_x + COORD_W'(LANES);
            end
        end
    end

endmodule

// File: rtl/fill_unit.sv
// Rectangle fill engine: walks an inclusive rectangle in raster order,
// emitting LANES-pixel beats with a lane mask on a valid/ready stream.
// Ports: start/abort/rect/color in; busy/done/err_bad_rect status out;
// pix_valid/pix_ready handshake with pix_x/pix_y/pix_mask/pix_color beat.
module fill_unit
    import gfx_pkg::*;
#(
    parameter int COORD_W = 16,
    parameter int COLOR_W = 32,
    parameter int LANES   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               err_bad_rect,
    input  logic [COLOR_W-1:0] color,
    input  logic [COORD_W-1:0] xmin,
    input  logic [COORD_W-1:0] ymin,
    input  logic [COORD_W-1:0] xmax,
    input  logic [COORD_W-1:0] ymax,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [LANES-1:0]   pix_mask,
    output logic [COLOR_W-1:0] pix_color
);

    fill_state_t state;
    fill_state_t state_nx;

    logic [COORD_W-1:0] cfg_xmin;
    logic [COORD_W-1:0] cfg_xmax;
    logic [COORD_W-1:0] cfg_ymax;
    logic [COLOR_W-1:0] cfg_color;
    logic               cfg_bad;

    logic               rect_bad;
    logic               load;
    logic               hs;
    logic               last;
    logic [LANES-1:0]   walk_mask;

    assign rect_bad = (xmin > xmax) || (ymin > ymax);
    assign load     = (state == IDLE) && start;
    assign hs       = pix_valid && pix_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A handshake coinciding with abort still completes in the walker;
    // the FSM simply leaves RUN afterwards.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = rect_bad ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort || (hs && last)) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ymin is only needed to seed the walker, so it is not kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_xmin  <= '0;
            cfg_xmax  <= '0;
            cfg_ymax  <= '0;
            cfg_color <= '0;
            cfg_bad   <= 1'b0;
        end else if (load) begin
            cfg_xmin  <= xmin;
            cfg_xmax  <= xmax;
            cfg_ymax  <= ymax;
            cfg_color <= color;
            cfg_bad   <= rect_bad;
        end
    end

    fill_walker #(
        .COORD_W(COORD_W),
        .LANES  (LANES)
    ) u_walker (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .load_x(xmin),
        .load_y(ymin),
        .step  (hs),
        .xmin  (cfg_xmin),
        .xmax  (cfg_xmax),
        .ymax  (cfg_ymax),
        .pix_x (pix_x),
        .pix_y (pix_y),
        .mask  (walk_mask),
        .last  (last)
    );

    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign err_bad_rect = done && cfg_bad;
    assign pix_valid    = (state == RUN);
    assign pix_mask     = pix_valid ? walk_mask : '0;
    assign pix_color    = cfg_color;

endmodule

// File: tb/tb_fill_unit.sv
// Directed bench for fill_unit: three instances (LANES=1, LANES=4,
// LANES=4 with 8-bit coordinates) sharing one clock and reset.
module tb_fill_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // instance a: LANES=1, 16-bit coords
    logic        a_start, a_abort, a_ready;
    logic        a_busy, a_done, a_err, a_valid;
    logic [15:0] a_xmin, a_ymin, a_xmax, a_ymax, a_x, a_y;
    logic [31:0] a_color, a_pcolor;
    logic [0:0]  a_mask;

    // instance b: LANES=4, 16-bit coords
    logic        b_start, b_abort, b_ready;
    logic        b_busy, b_done, b_err, b_valid;
    logic [15:0] b_xmin, b_ymin, b_xmax, b_ymax, b_x, b_y;
    logic [31:0] b_color, b_pcolor;
    logic [3:0]  b_mask;

    // instance c: LANES=4, 8-bit coords
    logic        c_start, c_abort, c_ready;
    logic        c_busy, c_done, c_err, c_valid;
    logic [7:0]  c_xmin, c_ymin, c_xmax, c_ymax, c_x, c_y;
    logic [31:0] c_color, c_pcolor;
    logic [3:0]  c_mask;

    fill_unit #(.COORD_W(16), .COLOR_W(32), .LANES(1)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
        .busy(a_busy), .done(a_done), .err_bad_rect(a_err),
        .color(a_color), .xmin(a_xmin), .ymin(a_ymin),
        .xmax(a_xmax), .ymax(a_ymax), .pix_valid(a_valid),
        .pix_ready(a_ready), .pix_x(a_x), .pix_y(a_y),
        .pix_mask(a_mask), .pix_color(a_pcolor)
    );

    fill_unit #(.COORD_W(16), .COLOR_W(32), .LANES(4)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
        .busy(b_busy), .done(b_done), .err_bad_rect(b_err),
        .color(b_color), .xmin(b_xmin), .ymin(b_ymin),
        .xmax(b_xmax), .ymax(b_ymax), .pix_valid(b_valid),
        .pix_ready(b_ready), .pix_x(b_x), .pix_y(b_y),
        .pix_mask(b_mask), .pix_color(b_pcolor)
    );

    fill_unit #(.COORD_W(8), .COLOR_W(32), .LANES(4)) u_c (
        .clk(clk), .rst(rst), .start(c_start), .abort(c_abort),
        .busy(c_busy), .done(c_done), .err_bad_rect(c_err),
        .color(c_color), .xmin(c_xmin), .ymin(c_ymin),
        .xmax(c_xmax), .ymax(c_ymax), .pix_valid(c_valid),
        .pix_ready(c_ready), .pix_x(c_x), .pix_y(c_y),
        .pix_mask(c_mask), .pix_color(c_pcolor)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic [15:0] x0, y0, x1, y1);
        a_xmin = x0; a_ymin = y0; a_xmax = x1; a_ymax = y1;
        a_color = 32'hA5A5A5A5;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_color = 32'h0;
        a_xmax  = 16'h0;
    endtask

    task automatic start_b(input logic [15:0] x0, y0, x1, y1,
                           input logic [31:0] col);
        b_xmin = x0; b_ymin = y0; b_xmax = x1; b_ymax = y1;
        b_color = col;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_color = 32'h0;
        b_xmax  = 16'h0;
    endtask

    task automatic start_c(input logic [7:0] x0, y0, x1, y1);
        c_xmin = x0; c_ymin = y0; c_xmax = x1; c_ymax = y1;
        c_color = 32'hC0FFEE00;
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
    endtask

    // Walk rect (0,0)-(3,2) on instance a with ready tied high,
    // optionally aborting on beat abort_beat.
    task automatic walk_a(input int abort_beat, input int want_beats);
        int ex = 0;
        int ey = 0;
        int nb = 0;
        a_ready = 1'b1;
        for (int c = 0; c < 100 && a_valid; c++) begin
            n_tests++;
            if (a_x !== 16'(ex) || a_y !== 16'(ey) || a_mask !== 1'b1 ||
                a_pcolor !== 32'hA5A5A5A5) begin
                n_fail++;
                $display("FAIL a_beat%0d: x=%0d y=%0d m=%b col=%h, want x=%0d y=%0d m=1 col=a5a5a5a5",
                         nb, a_x, a_y, a_mask, a_pcolor, ex, ey);
            end
            nb++;
            if (ex == 3) begin
                ex = 0;
                ey++;
            end else begin
                ex++;
            end
            a_abort = (nb == abort_beat);
            tick();
            a_abort = 1'b0;
        end
        n_tests++;
        if (nb !== want_beats) begin
            n_fail++;
            $display("FAIL a_beat_count: got %0d, want %0d", nb, want_beats);
        end
        n_tests++;
        if (a_done !== 1'b1 || a_busy !== 1'b1 || a_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL a_done_pulse: done=%b busy=%b valid=%b, want 1 1 0",
                     a_done, a_busy, a_valid);
        end
        tick();
        n_tests++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL a_idle_after: done=%b busy=%b, want 0 0",
                     a_done, a_busy);
        end
        a_ready = 1'b0;
    endtask

    // Walk rect (1,0)-(6,1) on instance b with pct% ready.
    task automatic walk_b(input int pct);
        logic [15:0] tx [4] = '{16'd1, 16'd5, 16'd1, 16'd5};
        logic [15:0] ty [4] = '{16'd0, 16'd0, 16'd1, 16'd1};
        logic [3:0]  tm [4] = '{4'b1111, 4'b0011, 4'b1111, 4'b0011};
        logic [15:0] px = '0;
        logic [15:0] py = '0;
        logic [3:0]  pm = '0;
        logic        stalled = 1'b0;
        int          idx = 0;
        for (int c = 0; c < 400 && b_valid; c++) begin
            if (stalled) begin
                n_tests++;
                if (b_x !== px || b_y !== py || b_mask !== pm) begin
                    n_fail++;
                    $display("FAIL b_hold: x=%0d y=%0d m=%b, want x=%0d y=%0d m=%b",
                             b_x, b_y, b_mask, px, py, pm);
                end
            end
            n_tests++;
            if (idx > 3) begin
                n_fail++;
                $display("FAIL b_extra_beat: got beat %0d, want 4 total", idx);
            end else if (b_x !== tx[idx] || b_y !== ty[idx] ||
                         b_mask !== tm[idx] || b_pcolor !== 32'h12345678) begin
                n_fail++;
                $display("FAIL b_beat%0d: x=%0d y=%0d m=%b col=%h, want x=%0d y=%0d m=%b col=12345678",
                         idx, b_x, b_y, b_mask, b_pcolor, tx[idx], ty[idx], tm[idx]);
            end
            b_ready = ($urandom_range(0, 99) < pct);
            px = b_x;
            py = b_y;
            pm = b_mask;
            stalled = !b_ready;
            if (b_ready) idx++;
            tick();
        end
        b_ready = 1'b0;
        n_tests++;
        if (idx !== 4) begin
            n_fail++;
            $display("FAIL b_beat_count: got %0d, want 4", idx);
        end
        n_tests++;
        if (b_done !== 1'b1 || b_valid !== 1'b0 || b_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b_done_pulse: done=%b valid=%b err=%b, want 1 0 0",
                     b_done, b_valid, b_err);
        end
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({a_busy, a_done, a_err, a_valid, a_mask} !== 5'b0 ||
            a_x !== 16'h0 || a_y !== 16'h0 || a_pcolor !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_a: b/d/e/v/m=%b%b%b%b%b x=%0d y=%0d col=%h, want all 0",
                     a_busy, a_done, a_err, a_valid, a_mask, a_x, a_y, a_pcolor);
        end
        n_tests++;
        if ({b_busy, b_done, b_err, b_valid} !== 4'b0 || b_mask !== 4'h0 ||
            b_x !== 16'h0 || b_y !== 16'h0 || b_pcolor !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_b: b/d/e/v=%b%b%b%b m=%b x=%0d y=%0d col=%h, want all 0",
                     b_busy, b_done, b_err, b_valid, b_mask, b_x, b_y, b_pcolor);
        end
        n_tests++;
        if ({c_busy, c_done, c_err, c_valid} !== 4'b0 || c_mask !== 4'h0 ||
            c_x !== 8'h0 || c_y !== 8'h0 || c_pcolor !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_c: b/d/e/v=%b%b%b%b m=%b x=%0d y=%0d col=%h, want all 0",
                     c_busy, c_done, c_err, c_valid, c_mask, c_x, c_y, c_pcolor);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_lane;
        start_a(16'd0, 16'd0, 16'd3, 16'd2);
        n_tests++;
        if (a_busy !== 1'b1 || a_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL a_start: busy=%b valid=%b, want 1 1", a_busy, a_valid);
        end
        walk_a(0, 12);
    endtask

    task automatic test_multi_lane;
        start_b(16'd1, 16'd0, 16'd6, 16'd1, 32'h12345678);
        walk_b(100);
    endtask

    task automatic test_backpressure;
        b_ready = 1'b0;
        start_b(16'd1, 16'd0, 16'd6, 16'd1, 32'h12345678);
        walk_b(30);
    endtask

    task automatic test_empty_rect;
        start_b(16'd5, 16'd0, 16'd2, 16'd0, 32'h0BADBEEF);
        n_tests++;
        if (b_valid !== 1'b0 || b_done !== 1'b1 ||
            b_err !== 1'b1 || b_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_pulse: v=%b d=%b e=%b b=%b, want 0 1 1 1",
                     b_valid, b_done, b_err, b_busy);
        end
        tick();
        n_tests++;
        if (b_valid !== 1'b0 || b_done !== 1'b0 ||
            b_err !== 1'b0 || b_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_after: v=%b d=%b e=%b b=%b, want 0 0 0 0",
                     b_valid, b_done, b_err, b_busy);
        end
    endtask

    task automatic test_abort;
        start_a(16'd0, 16'd0, 16'd3, 16'd2);
        walk_a(3, 3);
        start_a(16'd0, 16'd0, 16'd3, 16'd2);
        walk_a(0, 12);
    endtask

    task automatic test_edge_coords;
        c_ready = 1'b1;
        start_c(8'd252, 8'd255, 8'd255, 8'd255);
        n_tests++;
        if (c_valid !== 1'b1 || c_x !== 8'd252 || c_y !== 8'd255 ||
            c_mask !== 4'b1111) begin
            n_fail++;
            $display("FAIL edge_beat: v=%b x=%0d y=%0d m=%b, want 1 252 255 1111",
                     c_valid, c_x, c_y, c_mask);
        end
        tick();
        n_tests++;
        if (c_valid !== 1'b0 || c_done !== 1'b1 || c_err !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_done: v=%b d=%b e=%b, want 0 1 0",
                     c_valid, c_done, c_err);
        end
        tick();
        n_tests++;
        if (c_valid !== 1'b0 || c_busy !== 1'b0 || c_done !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_no_wrap: v=%b b=%b d=%b, want 0 0 0",
                     c_valid, c_busy, c_done);
        end
    endtask

    task automatic test_start_while_busy;
        c_ready = 1'b0;
        start_c(8'd0, 8'd0, 8'd7, 8'd1);
        c_xmin = 8'd100; c_ymin = 8'd100; c_xmax = 8'd200; c_ymax = 8'd200;
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        n_tests++;
        if (c_valid !== 1'b1 || c_busy !== 1'b1 || c_x !== 8'd0 ||
            c_y !== 8'd0 || c_mask !== 4'b1111) begin
            n_fail++;
            $display("FAIL busy_start: v=%b b=%b x=%0d y=%0d m=%b, want 1 1 0 0 1111",
                     c_valid, c_busy, c_x, c_y, c_mask);
        end
        c_ready = 1'b1;
        tick();
        c_ready = 1'b0;
        n_tests++;
        if (c_valid !== 1'b1 || c_x !== 8'd4 || c_y !== 8'd0 ||
            c_mask !== 4'b1111) begin
            n_fail++;
            $display("FAIL busy_step: v=%b x=%0d y=%0d m=%b, want 1 4 0 1111",
                     c_valid, c_x, c_y, c_mask);
        end
    endtask

    task automatic test_reset_mid_walk;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (c_valid !== 1'b0 || c_done !== 1'b0 || c_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst: v=%b d=%b b=%b, want 0 0 0",
                     c_valid, c_done, c_busy);
        end
        tick();
        n_tests++;
        if (c_valid !== 1'b0 || c_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_after: v=%b d=%b, want 0 0", c_valid, c_done);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_start = 0; a_abort = 0; a_ready = 0; a_color = '0;
        a_xmin = '0; a_ymin = '0; a_xmax = '0; a_ymax = '0;
        b_start = 0; b_abort = 0; b_ready = 0; b_color = '0;
        b_xmin = '0; b_ymin = '0; b_xmax = '0; b_ymax = '0;
        c_start = 0; c_abort = 0; c_ready = 0; c_color = '0;
        c_xmin = '0; c_ymin = '0; c_xmax = '0; c_ymax = '0;
        test_reset();
        test_single_lane();
        test_multi_lane();
        test_backpressure();
        test_empty_rect();
        test_abort();
        test_edge_coords();
        test_start_while_busy();
        test_reset_mid_walk();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
